// File: rtl/module_hamming_encoder_tx.sv
// Hamming(7,4) transmit block: buffers 4-bit words in a FIFO, encodes each into a
// 7-bit codeword {i3,i2,i1,c2,i0,c1,c0} and shifts it out MSB first, BIT_CYCLES
// clocks per bit, followed by GAP_BITS idle bit-times.
// Optional feature: define HAMMING_ERR_INJECT_EN to add err_inj/err_pos, which flip
// one codeword bit at load time. Without the macro, codewords are always sent clean.
module module_hamming_encoder_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic       err_inj,
  input  logic [2:0] err_pos,
`endif
  output logic       tx_bit,
  output logic       tx_frame,
  output logic       tx_start,
  output logic [6:0] codeword_out,
  output logic       busy
);

  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MaxBits   = (GAP_BITS > 7) ? GAP_BITS : 7;
  localparam int unsigned TimerW    = $clog2(BIT_CYCLES * MaxBits + 1);
  localparam int unsigned GapCycles = GAP_BITS * BIT_CYCLES;

  localparam logic [CountW-1:0] FifoFull = CountW'(FIFO_DEPTH);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(BIT_CYCLES - 1);
  // Unused when GAP_BITS=0; guarded so the constant never underflows.
  localparam logic [TimerW-1:0] GapLast  = (GapCycles > 0) ? TimerW'(GapCycles - 1) : '0;
  localparam logic [2:0]        IdxMsb   = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } state_e;

  // Encoder: parity bits cover the standard Hamming position groups.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic c0, c1, c2;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], c2, d[0], c1, c0};
  endfunction

  // FIFO storage and bookkeeping
  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Frame datapath
  state_e            state_q, state_d;
  logic [3:0]        word_q;
  logic [6:0]        cw_q;
  logic [6:0]        cw_load;
  logic              load;
  logic [2:0]        idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);

  // Ready is a pure function of the registered count: no pop look-ahead.
  assign data_ready = ~fifo_full;
  assign push       = data_valid & ~fifo_full;

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Codeword to load: clean encode, optionally with one bit flipped.
  always_comb begin
    cw_load = encode(word_q);
`ifdef HAMMING_ERR_INJECT_EN
    // err_pos=7 is the "no error" code, so only positions 0..6 flip.
    if (err_inj && (err_pos != 3'd7)) begin
      cw_load[err_pos] = ~cw_load[err_pos];
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state, pop/load strobes, and bit/gap timer sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        // Uses registered count, so a word pushed this cycle waits one cycle.
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load    = 1'b1;
        idx_d   = IdxMsb;
        timer_d = '0;
        state_d = StShift;
      end
      StShift: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (idx_q == 3'd0) begin
            state_d = (GAP_BITS == 0) ? StIdle : StGap;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Frame datapath registers: popped word, held codeword, bit index, timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cw_q    <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      if (pop) begin
        word_q <= mem_q[rd_ptr_q];
      end
      if (load) begin
        cw_q <= cw_load;
      end
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign tx_frame     = (state_q == StShift);
  assign tx_bit       = tx_frame ? cw_q[idx_q] : 1'b1;
  assign tx_start     = tx_frame && (idx_q == IdxMsb) && (timer_q == '0);
  assign codeword_out = cw_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_module_hamming_encoder_tx.sv
// Bench for module_hamming_encoder_tx (BIT_CYCLES=2, GAP_BITS=1, FIFO_DEPTH=4).
// Reference: Hamming positions 1..7 with parity at 1,2,4; decode by syndrome.
module tb_module_hamming_encoder_tx;

  localparam int BC = 2;
  localparam int GB = 1;
  localparam int FD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx_bit;
  logic       tx_frame;
  logic       tx_start;
  logic [6:0] codeword_out;
  logic       busy;
`ifdef HAMMING_ERR_INJECT_EN
  logic       err_inj;
  logic [2:0] err_pos;
`endif

  module_hamming_encoder_tx #(
    .FIFO_DEPTH(FD),
    .BIT_CYCLES(BC),
    .GAP_BITS  (GB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
`ifdef HAMMING_ERR_INJECT_EN
    .err_inj     (err_inj),
    .err_pos     (err_pos),
`endif
    .tx_bit      (tx_bit),
    .tx_frame    (tx_frame),
    .tx_start    (tx_start),
    .codeword_out(codeword_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fcnt     = 0;
  int last_push_cyc = 0;

  logic [6:0] rx_sh;
  logic [6:0] rx_q[$];
  logic [6:0] cwo_q[$];
  int         start_q[$];
  int         end_q[$];
  logic [6:0] exp_q[$];
  logic [3:0] expw_q[$];

  logic [6:0] rxa[16];
  int         st[16];
  int         en[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] v;
    int dpos[4];
    dpos = '{3, 5, 6, 7};
    v = '0;
    for (int k = 0; k < 4; k++) v[dpos[k]-1] = d[k];
    for (int j = 0; j < 3; j++) begin
      int p;
      logic par;
      p = 1 << j;
      par = 1'b0;
      for (int q = 1; q <= 7; q++) if (((q & p) != 0) && (q != p)) par = par ^ v[q-1];
      v[p-1] = par;
    end
    return v;
  endfunction

  function automatic logic [3:0] dec(input logic [6:0] r);
    logic [6:0] v;
    int s;
    v = r;
    s = 0;
    for (int q = 1; q <= 7; q++) if (v[q-1]) s = s ^ q;
    if (s != 0) v[s-1] = ~v[s-1];
    return {v[6], v[5], v[4], v[2]};
  endfunction

  // Serial-line monitor: rebuilds frames and checks framing on every cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      fcnt = 0;
    end else if (tx_frame) begin
      chk("tx_start_position", tx_start, (fcnt == 0));
      if (fcnt == 0) start_q.push_back(cyc);
      if ((fcnt % BC) == 0) rx_sh = {rx_sh[5:0], tx_bit};
      else chk("bit_hold", tx_bit, rx_sh[0]);
      fcnt++;
      if (fcnt == 7 * BC) begin
        rx_q.push_back(rx_sh);
        cwo_q.push_back(codeword_out);
        end_q.push_back(cyc);
        fcnt = 0;
      end
    end else begin
      chk("idle_tx_start", tx_start, 1'b0);
      chk("idle_tx_bit", tx_bit, 1'b1);
      chk("frame_length", fcnt, 0);
    end
  end

  task automatic push(input logic [3:0] w);
    int n;
    logic [6:0] cw;
    n = 0;
    @(negedge clk);
    while (!data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", data_ready, 1'b1);
    data_valid = 1'b1;
    data_in    = w;
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    data_valid = 1'b0;
    data_in    = 4'($urandom);
    cw = enc(w);
`ifdef HAMMING_ERR_INJECT_EN
    if (err_inj && err_pos != 3'd7) cw[err_pos] = ~cw[err_pos];
`endif
    exp_q.push_back(cw);
    expw_q.push_back(w);
  endtask

  task automatic check_frames(input int n, input bit flips);
    int waited;
    logic [6:0] r, c, x, mask;
    logic [3:0] w;
    waited = 0;
    while (rx_q.size() < n && waited < n * 40 + 100) begin
      @(negedge clk);
      waited++;
    end
    #1;
    chk("frame_count", (rx_q.size() >= n), 1'b1);
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() == 0 || exp_q.size() == 0) break;
      r = rx_q.pop_front();
      c = cwo_q.pop_front();
      st[i] = start_q.pop_front();
      en[i] = end_q.pop_front();
      x = exp_q.pop_front();
      w = expw_q.pop_front();
      rxa[i] = r;
      chk("frame_bits", r, x);
      chk("frame_codeword_out", c, x);
      chk("frame_decode", dec(r), w);
      if (flips) begin
        for (int b = 0; b < 8; b++) begin
          mask = (b < 7) ? (7'd1 << b) : 7'd0;
          chk("flip_decode", dec(r ^ mask), w);
        end
      end
    end
  endtask

  initial begin
    int acc;
    int n;
    bit found;
    logic [3:0] w;

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 4'h0;
    rx_sh      = '0;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj = 1'b0;
    err_pos = 3'd7;
`endif
    #12;
    chk("rst_data_ready", data_ready, 1'b1);
    chk("rst_tx_bit", tx_bit, 1'b1);
    chk("rst_tx_frame", tx_frame, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_codeword_out", codeword_out, 7'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word into an idle block: encoding, bit order and latency
    push(4'b1011);
    check_frames(1, 1'b0);
    chk("t1_latency", st[0] - last_push_cyc, 3);
    chk("t1_literal", rxa[0], 7'b1010101);
    chk("t1_codeword_held", codeword_out, 7'b1010101);

    // Three back-to-back frames
    push(4'b0000);
    push(4'b1111);
    push(4'b0001);
    check_frames(3, 1'b0);
    chk("t2_f0", rxa[0], 7'b0000000);
    chk("t2_f1", rxa[1], 7'b1111111);
    chk("t2_f2", rxa[2], 7'b0000111);
    chk("t2_gap01", st[1] - en[0] - 1, GB * BC + 2);
    chk("t2_gap12", st[2] - en[1] - 1, GB * BC + 2);

    // Hold data_valid for 8 cycles while a frame is on the wire
    push(4'($urandom));
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      found = tx_frame;
      n++;
    end
    chk("burst_frame_seen", found, 1'b1);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      w = 4'($urandom);
      data_valid = 1'b1;
      data_in    = w;
      if (data_ready) begin
        acc++;
        exp_q.push_back(enc(w));
        expw_q.push_back(w);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("burst_accepted", acc, FD);
    chk("burst_ready_low", data_ready, 1'b0);
    chk("burst_busy", busy, 1'b1);
    check_frames(1 + FD, 1'b0);

    // All 16 words, each decoded with no error and with every single-bit error
    for (int i = 0; i < 16; i++) push(4'(i));
    check_frames(16, 1'b1);

    // Random words with random idle spacing and data_in noise while not valid
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 20)) begin
        @(negedge clk);
        data_in = 4'($urandom);
      end
      push(4'($urandom));
    end
    check_frames(12, 1'b1);
    repeat (30) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

`ifdef HAMMING_ERR_INJECT_EN
    err_inj = 1'b1;
    err_pos = 3'd2;
    push(4'b1011);
    check_frames(1, 1'b0);
    chk("inj_pos2", rxa[0], 7'b1010001);
    err_pos = 3'd7;
    push(4'b1011);
    check_frames(1, 1'b0);
    chk("inj_pos7", rxa[0], 7'b1010101);
    for (int i = 0; i < 6; i++) begin
      err_pos = 3'($urandom);
      push(4'($urandom));
      check_frames(1, 1'b0);
    end
    err_inj = 1'b0;
    err_pos = 3'd7;
`endif

    // Reset during bit 3 of a frame, with more words buffered behind it
    push(4'($urandom));
    push(4'($urandom));
    push(4'($urandom));
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      #1;
      found = tx_frame && (fcnt == 3 * BC + 1);
      n++;
    end
    chk("mid_frame_reached", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx_bit", tx_bit, 1'b1);
    chk("mrst_tx_frame", tx_frame, 1'b0);
    chk("mrst_tx_start", tx_start, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_codeword_out", codeword_out, 7'd0);
    chk("mrst_data_ready", data_ready, 1'b1);
    rx_q.delete();
    cwo_q.delete();
    start_q.delete();
    end_q.delete();
    exp_q.delete();
    expw_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    chk("post_rst_no_frame", start_q.size(), 0);
    chk("post_rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
